// File: rtl/ncc.sv
// NCC descriptor normalizer: gathers a 64-pixel patch, removes its mean and divides each deviation by the L2 norm.
// Build option: define NCC_ROUND_EN to round quotients half away from zero instead of truncating.
module ncc #(
    parameter int NPIX  = 64,
    parameter int FRAC  = 27,
    parameter int IBITS = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           desc_data_ready,
    input  logic [31:0]                    desc_data_in,
    output logic signed [IBITS-1:-FRAC]    descPixelOut [NPIX-1:0]
);
    localparam int NWORDS = NPIX / 4;
    localparam int WCW    = $clog2(NWORDS);
    localparam int IXW    = $clog2(NPIX);
    localparam int SUMW   = $clog2(NPIX * 255 + 1);
    localparam int EW     = SUMW + 2;
    localparam int SSW    = 36;
    localparam int RW     = SSW / 2;
    localparam int SQW    = RW + 4;
    localparam int OW     = IBITS + FRAC;
    localparam int DW     = EW + FRAC;
    localparam int RMW    = RW + 2;
    localparam int CW     = $clog2(OW);

    typedef enum logic [2:0] {LOAD, CENTER, SQRT, DPREP, DIVIDE, WRITE, ZERO} state_t;

    state_t state_reg, state_next;

    logic [WCW-1:0]        wcnt_reg;
    logic [SUMW-1:0]       sum_reg;
    logic [IXW-1:0]        idx_reg;
    logic [CW-1:0]         cnt_reg;
    logic [SSW-1:0]        ss_reg;
    logic [SQW-1:0]        sq_rem_reg;
    logic [RW-1:0]         root_reg;
    logic [RMW-1:0]        dv_rem_reg;
    logic [OW-1:0]         dv_n_reg;
    logic                  neg_reg;
    logic signed [EW-1:0]  e_rd_reg;

    logic [7:0]            pix_mem [4][NWORDS];
    logic signed [EW-1:0]  e_mem [NPIX];

    logic [7:0]            pix_sel;
    logic [SUMW-1:0]       word_sum;
    logic signed [EW-1:0]  e_val;
    logic signed [2*EW-1:0] e_sq;
    logic [SQW-1:0]        rem_sh, trial;
    logic                  sq_ge;
    logic [RMW-1:0]        div_rs;
    logic                  div_ge;
    logic [EW-1:0]         mag;
    logic [DW-1:0]         dividend;
    logic [IXW-1:0]        e_raddr;
    logic                  last_idx;
    logic                  wr_en;
    logic [OW-1:0]         wr_val;

    // Four byte lanes, one bank each, so a whole word lands in a single cycle.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            always_ff @(posedge clk) begin
                if (state_reg == LOAD && desc_data_ready)
                    pix_mem[gi][wcnt_reg] <= desc_data_in[31-8*gi -: 8];
            end
        end
    endgenerate

    always_comb begin
        word_sum = sum_reg + SUMW'(desc_data_in[31:24]) + SUMW'(desc_data_in[23:16])
                           + SUMW'(desc_data_in[15:8])  + SUMW'(desc_data_in[7:0]);
        pix_sel  = pix_mem[idx_reg[1:0]][idx_reg[IXW-1:2]];
        e_val    = $signed({2'b00, pix_sel, IXW'(0)}) - $signed({2'b00, sum_reg});
        e_sq     = (2*EW)'(e_val) * (2*EW)'(e_val);
        last_idx = (idx_reg == IXW'(NPIX - 1));

        rem_sh   = {sq_rem_reg[SQW-3:0], ss_reg[SSW-1 -: 2]};
        trial    = SQW'({root_reg, 2'b01});
        sq_ge    = (rem_sh >= trial);

        div_rs   = {dv_rem_reg[RMW-2:0], dv_n_reg[OW-1]};
        div_ge   = (div_rs >= RMW'(root_reg));

        mag      = e_rd_reg[EW-1] ? EW'(-e_rd_reg) : EW'(e_rd_reg);
`ifdef NCC_ROUND_EN
        dividend = {mag, FRAC'(0)} + DW'(root_reg >> 1);
`else
        dividend = {mag, FRAC'(0)};
`endif
        // Element i+1 is prefetched while element i divides, ready for the writeback cycle.
        e_raddr  = (state_reg == DIVIDE) ? idx_reg + IXW'(1) : '0;

        wr_en    = (state_reg == WRITE) || (state_reg == ZERO);
        wr_val   = (state_reg == ZERO) ? '0 : (neg_reg ? OW'(-dv_n_reg) : dv_n_reg);
    end

    always_ff @(posedge clk) begin
        if (state_reg == CENTER)
            e_mem[idx_reg] <= e_val;
        e_rd_reg <= e_mem[e_raddr];
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= LOAD;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (desc_data_ready && wcnt_reg == WCW'(NWORDS - 1)) state_next = CENTER;
            CENTER:  if (last_idx) state_next = SQRT;
            SQRT:    if (cnt_reg == CW'(RW - 1)) state_next = DPREP;
            DPREP:   state_next = (root_reg == '0) ? ZERO : DIVIDE;
            DIVIDE:  if (cnt_reg == CW'(OW - 1)) state_next = WRITE;
            WRITE:   state_next = last_idx ? LOAD : DIVIDE;
            ZERO:    if (last_idx) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_reg   <= '0;
            sum_reg    <= '0;
            idx_reg    <= '0;
            cnt_reg    <= '0;
            ss_reg     <= '0;
            sq_rem_reg <= '0;
            root_reg   <= '0;
            dv_rem_reg <= '0;
            dv_n_reg   <= '0;
            neg_reg    <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: if (desc_data_ready) begin
                    wcnt_reg   <= wcnt_reg + WCW'(1);
                    sum_reg    <= word_sum;
                    ss_reg     <= '0;
                    sq_rem_reg <= '0;
                    root_reg   <= '0;
                    idx_reg    <= '0;
                end
                CENTER: begin
                    ss_reg  <= ss_reg + SSW'($unsigned(e_sq));
                    idx_reg <= idx_reg + IXW'(1);
                    cnt_reg <= '0;
                end
                SQRT: begin
                    // Restoring square root: two radicand bits consumed per cycle.
                    ss_reg     <= ss_reg << 2;
                    sq_rem_reg <= sq_ge ? rem_sh - trial : rem_sh;
                    root_reg   <= {root_reg[RW-2:0], sq_ge};
                    cnt_reg    <= cnt_reg + CW'(1);
                end
                DPREP, WRITE: begin
                    // The high dividend bits start as the partial remainder; quotient fits in OW bits.
                    dv_rem_reg <= RMW'(dividend >> OW);
                    dv_n_reg   <= dividend[OW-1:0];
                    neg_reg    <= e_rd_reg[EW-1];
                    cnt_reg    <= '0;
                    if (state_reg == WRITE) begin
                        idx_reg <= idx_reg + IXW'(1);
                        if (last_idx) sum_reg <= '0;
                    end else begin
                        idx_reg <= '0;
                    end
                end
                DIVIDE: begin
                    dv_rem_reg <= div_ge ? div_rs - RMW'(root_reg) : div_rs;
                    dv_n_reg   <= {dv_n_reg[OW-2:0], div_ge};
                    cnt_reg    <= cnt_reg + CW'(1);
                end
                ZERO: begin
                    idx_reg <= idx_reg + IXW'(1);
                    if (last_idx) sum_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NPIX; gi++) begin : g_out
            always_ff @(posedge clk) begin
                if (rst)
                    descPixelOut[gi] <= '0;
                else if (wr_en && idx_reg == IXW'(gi))
                    descPixelOut[gi] <= wr_val;
            end
        end
    endgenerate

endmodule

// File: tb/tb_ncc.sv
// Directed bench for ncc: fixed patches with hand-computed normalized outputs.
module tb_ncc;
    logic              clk = 1'b0;
    logic              rst;
    logic              desc_data_ready;
    logic [31:0]       desc_data_in;
    logic signed [5:-27] descPixelOut [63:0];

    int n_cmp = 0;
    int n_bad = 0;

    localparam int K_A    = 0;
    localparam int K_FLAT = 1;
    localparam int K_PIX  = 2;
    localparam int K_ZERO = 3;

    ncc dut (
        .clk             (clk),
        .rst             (rst),
        .desc_data_ready (desc_data_ready),
        .desc_data_in    (desc_data_in),
        .descPixelOut    (descPixelOut)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [32:0] expected(input int kind, input int i);
        logic signed [32:0] v;
        v = '0;
        if (kind == K_A) begin
            case (i % 4)
                0: v = -33'sd21235932;
                1: v = -33'sd10617966;
                2: v =  33'sd10617966;
                default: v = 33'sd21235932;
            endcase
        end else if (kind == K_PIX) begin
`ifdef NCC_ROUND_EN
            v = (i == 0) ? 33'sd133173232 : -33'sd2113861;
`else
            v = (i == 0) ? 33'sd133173232 : -33'sd2113860;
`endif
        end
        return v;
    endfunction

    task automatic check(input string tag, input int i, input logic signed [32:0] exp);
        n_cmp++;
        assert (descPixelOut[i] === exp) else begin
            n_bad++;
            $error("FAIL %s[%0d] observed %0d expected %0d", tag, i, descPixelOut[i], exp);
        end
    endtask

    task automatic check_all(input string tag, input int kind);
        for (int i = 0; i < 64; i++) check(tag, i, expected(kind, i));
        $display("check %s: %0d compared so far, %0d bad", tag, n_cmp, n_bad);
    endtask

    task automatic send_word(input logic [31:0] w);
        desc_data_ready = 1'b1;
        desc_data_in    = w;
        tick();
        desc_data_ready = 1'b0;
        desc_data_in    = '0;
    endtask

    task automatic send_desc(input int kind, input bit gap);
        logic [31:0] w;
        for (int k = 0; k < 16; k++) begin
            case (kind)
                K_A:     w = 32'h01020405;
                K_FLAT:  w = 32'h7F7F7F7F;
                default: w = (k == 0) ? 32'hFF000000 : 32'h00000000;
            endcase
            send_word(w);
            if (gap) tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst             = 1'b1;
        desc_data_ready = 1'b0;
        desc_data_in    = '0;
        do_reset();
        check_all("reset", K_ZERO);

        // A single word never completes a descriptor.
        send_word(32'h01020405);
        repeat (2400) tick();
        check_all("partial", K_ZERO);
        do_reset();

        send_desc(K_A, 1'b0);
        repeat (2300) tick();
        check_all("pat_a", K_A);

        send_desc(K_FLAT, 1'b0);
        repeat (2300) tick();
        check_all("flat", K_FLAT);

        // Strobes during division must be dropped.
        send_desc(K_PIX, 1'b0);
        repeat (1000) tick();
        for (int j = 0; j < 4; j++) send_word(32'hDEADBEEF);
        repeat (1400) tick();
        check_all("pix", K_PIX);

        send_desc(K_A, 1'b1);
        repeat (2300) tick();
        check_all("gapped", K_A);

        // Reset in the middle of division.
        send_desc(K_PIX, 1'b0);
        repeat (1000) tick();
        check("mid_new", 0, expected(K_PIX, 0));
        check("mid_old", 63, expected(K_A, 63));
        do_reset();
        check_all("mid_rst", K_ZERO);

        send_desc(K_A, 1'b0);
        repeat (2300) tick();
        check_all("post_rst", K_A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
